// File: rtl/approx_adder_pipe.sv
// Pipelined adder with per-op exact / lower-part-constant approximate mode.
// Upper carry chain is cut into PIPE_STAGES segments, carry held in sum bit WIDTH.
module approx_adder_pipe #(
   parameter int WIDTH       = 32,
   parameter int APPROX_BITS = 8,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH:0]       out_sum,
   output logic                 out_mode,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] approx_cnt
);

   localparam int K   = APPROX_BITS;
   localparam int SEG = (WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

   if (APPROX_BITS < 0 || APPROX_BITS > WIDTH - 3) begin : g_bad_approx
      $error("approx_adder_pipe: APPROX_BITS must be in 0..WIDTH-3");
   end
   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("approx_adder_pipe: PIPE_STAGES must be in 1..4");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cnt
      $error("approx_adder_pipe: CNT_WIDTH must be at least 1");
   end

   // Ripple bits lo..hi; carry enters and leaves through acc[WIDTH].
   function automatic logic [WIDTH:0] seg_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH:0]   acc,
                                              input int               lo,
                                              input int               hi);
      logic [WIDTH:0] r;
      logic           c;
      r = acc;
      c = acc[WIDTH];
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= lo && i <= hi) begin
            r[i] = acc[i] | (a[i] ^ b[i] ^ c);
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         end
      end
      r[WIDTH] = c;
      return r;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                 en;
   logic                 accept;
   logic [WIDTH-1:0]     pa;
   logic [WIDTH-1:0]     pb;
   logic [WIDTH:0]       acc0;

   logic [WIDTH-1:0]     a_s     [PIPE_STAGES];
   logic [WIDTH-1:0]     b_s     [PIPE_STAGES];
   logic [WIDTH:0]       acc_s   [PIPE_STAGES];
   logic                 mode_s  [PIPE_STAGES];
   logic                 vld_s   [PIPE_STAGES];
   logic [WIDTH:0]       nxt_acc [PIPE_STAGES];

   logic [WIDTH-1:0]     a_p     [PIPE_STAGES];
   logic [WIDTH-1:0]     b_p     [PIPE_STAGES];
   logic [WIDTH:0]       sum_p   [PIPE_STAGES];
   logic                 mode_p  [PIPE_STAGES];
   logic                 vld_p   [PIPE_STAGES];

   assign en        = !vld_p[PIPE_STAGES-1] || out_ready;
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign out_valid = vld_p[PIPE_STAGES-1];
   assign out_sum   = sum_p[PIPE_STAGES-1];
   assign out_mode  = mode_p[PIPE_STAGES-1];

   // Approx mode rewrites the low K+2 operand bits so the plain adder yields
   // ones below K, a|b at K, zero at K+1 and carry c into K+2; a&b at K+1 is
   // pre-seeded in the accumulator and OR-ed in.
   always_comb begin
      pa   = in_a;
      pb   = in_b;
      acc0 = '0;
      if (in_mode) begin
         for (int i = 0; i < K; i++) begin
            pa[i] = 1'b1;
            pb[i] = 1'b0;
         end
         pa[K]     = in_a[K] | in_b[K];
         pb[K]     = 1'b0;
         pa[K+1]   = in_a[K+1] & in_b[K+1];
         pb[K+1]   = in_a[K+1] & in_b[K+1];
         acc0[K+1] = in_a[K] & in_b[K];
      end
   end

   always_comb begin
      a_s[0]    = pa;
      b_s[0]    = pb;
      acc_s[0]  = acc0;
      mode_s[0] = in_mode;
      vld_s[0]  = in_valid;
      for (int s = 1; s < PIPE_STAGES; s++) begin
         a_s[s]    = a_p[s-1];
         b_s[s]    = b_p[s-1];
         acc_s[s]  = sum_p[s-1];
         mode_s[s] = mode_p[s-1];
         vld_s[s]  = vld_p[s-1];
      end
   end

   always_comb begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
         nxt_acc[s] = seg_add(a_s[s], b_s[s], acc_s[s], s * SEG, (s + 1) * SEG - 1);
      end
   end

   // Stage registers: control plus the visible result, all frozen when !en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            vld_p[s]  <= 1'b0;
            mode_p[s] <= 1'b0;
            sum_p[s]  <= '0;
         end
         approx_cnt <= '0;
      end else begin
         if (cnt_clr) begin
            approx_cnt <= '0;
         end else if (accept && in_mode) begin
            approx_cnt <= sat_inc(approx_cnt);
         end
         if (en) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
               vld_p[s]  <= vld_s[s];
               mode_p[s] <= mode_s[s];
               sum_p[s]  <= nxt_acc[s];
            end
         end
      end
   end

   // Delayed operand bits for the segments still to be added.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            a_p[s] <= a_s[s];
            b_p[s] <= b_s[s];
         end
      end
   end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Bench for approx_adder_pipe: directed ops, counter and reset checks on a
// default instance, plus a scoreboarded random sweep over stage count and K.
module tb_approx_adder_pipe;

   localparam int NCFG = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: arithmetic statement of the exact / approximate sum rules.
   function automatic logic [63:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                           input logic mode, input int k);
      logic [63:0] a64, b64, s, c, ak, bk;
      a64 = {32'd0, a};
      b64 = {32'd0, b};
      if (!mode) return a64 + b64;
      ak = (a64 >> k) & 64'd1;
      bk = (b64 >> k) & 64'd1;
      c  = (a64 >> (k + 1)) & (b64 >> (k + 1)) & 64'd1;
      s  = ((64'd1 << k) - 64'd1) | ((ak | bk) << k) | ((ak & bk) << (k + 1));
      s  = s | (((a64 >> (k + 2)) + (b64 >> (k + 2)) + c) << (k + 2));
      return s;
   endfunction

   // ---------------- default instance ----------------
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
   logic [31:0] in_a = '0, in_b = '0;
   logic        in_ready, out_valid, out_mode;
   logic [32:0] out_sum;
   logic [15:0] approx_cnt;

   approx_adder_pipe #(.WIDTH(32), .APPROX_BITS(8), .PIPE_STAGES(2), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_mode(out_mode),
      .cnt_clr(cnt_clr), .approx_cnt(approx_cnt));

   // ---------------- CNT_WIDTH=4 instance ----------------
   logic        sw_rst_n = 1'b0;
   logic        c4_valid = 1'b0;
   logic        c4_in_ready, c4_out_valid, c4_mode;
   logic [32:0] c4_sum;
   logic [3:0]  c4_cnt;

   approx_adder_pipe #(.WIDTH(32), .APPROX_BITS(8), .PIPE_STAGES(2), .CNT_WIDTH(4)) u_c4 (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(c4_valid), .in_ready(c4_in_ready),
      .in_a(32'd0), .in_b(32'd0), .in_mode(1'b1), .out_valid(c4_out_valid),
      .out_ready(1'b1), .out_sum(c4_sum), .out_mode(c4_mode),
      .cnt_clr(1'b0), .approx_cnt(c4_cnt));

   // ---------------- sweep instances ----------------
   logic        sw_valid = 1'b0, sw_mode = 1'b0, sw_ready = 1'b1;
   logic        lat_phase = 1'b0, sw_done = 1'b0;
   logic [31:0] sw_a = '0, sw_b = '0;
   logic        sw_in_ready  [NCFG];
   logic        sw_out_valid [NCFG];
   logic        sw_omode     [NCFG];
   logic [32:0] sw_sum       [NCFG];
   logic [15:0] sw_cnt       [NCFG];

   for (genvar g = 0; g < NCFG; g++) begin : g_sw
      localparam int S  = g / 3 + 1;
      localparam int KK = (g % 3 == 0) ? 0 : ((g % 3 == 1) ? 8 : 29);

      approx_adder_pipe #(.WIDTH(32), .APPROX_BITS(KK), .PIPE_STAGES(S), .CNT_WIDTH(16)) u (
         .clk(clk), .rst_n(sw_rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[g]),
         .in_a(sw_a), .in_b(sw_b), .in_mode(sw_mode), .out_valid(sw_out_valid[g]),
         .out_ready(sw_ready), .out_sum(sw_sum[g]), .out_mode(sw_omode[g]),
         .cnt_clr(1'b0), .approx_cnt(sw_cnt[g]));

      logic [63:0] q_exp [$];
      int          q_cyc [$];
      bit          q_lat [$];
      logic [63:0] held;
      bit          stalled = 1'b0;

      task automatic mon();
         logic [63:0] e, got;
         int          c;
         bit          l;
         got = {30'd0, sw_omode[g], sw_sum[g]};
         if (!sw_rst_n) begin
            q_exp.delete(); q_cyc.delete(); q_lat.delete();
            stalled = 1'b0;
            return;
         end
         if (stalled) check_eq($sformatf("sw%0d_hold", g), got, held);
         stalled = 1'b0;
         if (sw_valid && sw_in_ready[g]) begin
            q_exp.push_back((64'(sw_mode) << 33) | ref_sum(sw_a, sw_b, sw_mode, KK));
            q_cyc.push_back(cyc);
            q_lat.push_back(lat_phase);
         end
         if (sw_out_valid[g]) begin
            if (sw_ready) begin
               if (q_exp.size() == 0) begin
                  check_eq($sformatf("sw%0d_extra", g), 64'd1, 64'd0);
               end else begin
                  e = q_exp.pop_front();
                  c = q_cyc.pop_front();
                  l = q_lat.pop_front();
                  check_eq($sformatf("sw%0d_sum", g), got, e);
                  if (l) check_eq($sformatf("sw%0d_lat", g), 64'(cyc - c), 64'(S));
               end
            end else begin
               stalled = 1'b1;
               held    = got;
            end
         end
      endtask

      always @(negedge clk) mon();

      initial begin
         wait (sw_done);
         check_eq($sformatf("sw%0d_left", g), 64'(q_exp.size()), 64'd0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic mode, input logic [32:0] exp);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode;
      @(negedge clk);
      check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check_eq({tag, "_lat"}, 64'(n), 64'd2);
      check_eq({tag, "_sum"}, 64'(out_sum), 64'(exp));
      check_eq({tag, "_mode"}, 64'(out_mode), 64'(mode));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_sum", 64'(out_sum), 64'd0);
      check_eq("rst_mode", 64'(out_mode), 64'd0);
      check_eq("rst_cnt", 64'(approx_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; sw_rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", 64'(in_ready), 64'd1);

      do_op("exact_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
      do_op("apx_100", 32'h0000_0100, 32'h0000_0100, 1'b1, 33'h0_0000_03FF);
      do_op("apx_300", 32'h0000_0300, 32'h0000_0300, 1'b1, 33'h0_0000_07FF);
      do_op("apx_0", 32'h0, 32'h0, 1'b1, 33'h0_0000_00FF);
      do_op("exact_mix", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 33'h0_ACF1_3568);
      check_eq("cnt_3", 64'(approx_cnt), 64'd3);

      @(posedge clk); #1;
      in_valid = 1'b1; in_mode = 1'b1; cnt_clr = 1'b1; in_a = '0; in_b = '0;
      @(posedge clk); #1;
      in_valid = 1'b0; cnt_clr = 1'b0;
      check_eq("cnt_clr_pri", 64'(approx_cnt), 64'd0);
      repeat (3) @(posedge clk);
      do_op("apx_after_clr", 32'h0, 32'h0, 1'b1, 33'h0_0000_00FF);
      check_eq("cnt_after_clr", 64'(approx_cnt), 64'd1);

      @(posedge clk); #1;
      in_valid = 1'b1; in_mode = 1'b1; in_a = 32'd1; in_b = 32'd2;
      @(posedge clk); #1;
      in_a = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_valid", 64'(out_valid), 64'd0);
      check_eq("async_cnt", 64'(approx_cnt), 64'd0);
      check_eq("async_sum", 64'(out_sum), 64'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_idle", 64'(out_valid), 64'd0);
      do_op("post_rst_op", 32'h0000_0100, 32'h0000_0100, 1'b1, 33'h0_0000_03FF);

      @(posedge clk); #1;
      c4_valid = 1'b1;
      repeat (20) @(posedge clk);
      #1 c4_valid = 1'b0;
      check_eq("cnt4_sat", 64'(c4_cnt), 64'd15);

      repeat (300) begin
         @(posedge clk); #1;
         sw_valid = ($urandom_range(0, 3) != 0);
         sw_a     = $urandom;
         sw_b     = $urandom;
         if ($urandom_range(0, 7) == 0) sw_a = 32'hFFFF_FFFF;
         sw_mode  = 1'($urandom_range(0, 1));
         sw_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      sw_valid = 1'b0; sw_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 lat_phase = 1'b1;
      repeat (100) begin
         @(posedge clk); #1;
         sw_valid = ($urandom_range(0, 3) != 0);
         sw_a     = $urandom;
         sw_b     = $urandom;
         sw_mode  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      sw_valid = 1'b0;
      repeat (10) @(posedge clk);
      sw_done = 1'b1;
      #1;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
